// File: rtl/psram_byte_bridge.sv
// rtl/psram_byte_bridge.sv - byte request/response front end for the 32-bit PSRAM IP command port
// One-word read cache with write-through; calibration is synchronized locally.
module psram_byte_bridge #(
    parameter int WR_GAP     = 255,
    parameter int RD_TIMEOUT = 64,
    parameter bit CACHE_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [22:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        ready_o,
    output logic        busy,
    output logic        ip_cmd,
    output logic        ip_cmd_en,
    output logic [20:0] ip_addr,
    output logic [31:0] ip_wr_data,
    output logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_rd_data,
    input  logic        ip_rd_data_valid
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_GAP
    } state_t;

    localparam int CNT_MAX = (WR_GAP > RD_TIMEOUT) ? WR_GAP : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_q;
    logic [2:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        lane_q;
    logic              cache_valid_q;
    logic [20:0]       cache_tag_q;
    logic [31:0]       cache_word_q;
    logic [31:0]       cache_wr_d;
    logic              rsp_valid_q, rsp_err_q, ip_cmd_q, ip_cmd_en_q;
    logic [7:0]        rsp_rdata_q;
    logic [20:0]       ip_addr_q;
    logic [31:0]       ip_wr_data_q;
    logic [3:0]        ip_data_mask_q;
    logic              hit;

    assign ready_o      = sync_q[2];
    assign req_ready    = (state_q == S_IDLE) && ready_o;
    assign busy         = (state_q != S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign ip_cmd       = ip_cmd_q;
    assign ip_cmd_en    = ip_cmd_en_q;
    assign ip_addr      = ip_addr_q;
    assign ip_wr_data   = ip_wr_data_q;
    assign ip_data_mask = ip_data_mask_q;

    assign hit = CACHE_EN && cache_valid_q && (cache_tag_q == req_addr[22:2]);

    always_comb begin
        cache_wr_d = cache_word_q;
        cache_wr_d[{req_addr[1:0], 3'b000} +: 8] = req_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], calib_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_INIT;
            cnt_q          <= '0;
            lane_q         <= 2'b00;
            cache_valid_q  <= 1'b0;
            cache_tag_q    <= '0;
            cache_word_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= 8'h00;
            ip_cmd_q       <= 1'b0;
            ip_cmd_en_q    <= 1'b0;
            ip_addr_q      <= '0;
            ip_wr_data_q   <= '0;
            ip_data_mask_q <= 4'h0;
        end else begin
            ip_cmd_en_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            // Calibration loss outranks everything; a pending hit response is already registered.
            if (state_q != S_INIT && !ready_o) begin
                state_q       <= S_INIT;
                cache_valid_q <= 1'b0;
                if (state_q inside {S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE}) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= 8'hFF;
                end
            end else begin
                case (state_q)
                    S_INIT: begin
                        if (ready_o) state_q <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (req_valid && req_ready) begin
                            lane_q <= req_addr[1:0];
                            if (req_we) begin
                                ip_cmd_en_q    <= 1'b1;
                                ip_cmd_q       <= 1'b1;
                                ip_addr_q      <= req_addr[22:2];
                                ip_wr_data_q   <= {4{req_wdata}};
                                ip_data_mask_q <= ~(4'b0001 << req_addr[1:0]);
                                if (hit) cache_word_q <= cache_wr_d;
                                state_q        <= S_WR_ISSUE;
                            end else if (hit) begin
                                rsp_valid_q <= 1'b1;
                                rsp_rdata_q <= cache_word_q[{req_addr[1:0], 3'b000} +: 8];
                            end else begin
                                ip_cmd_en_q    <= 1'b1;
                                ip_cmd_q       <= 1'b0;
                                ip_addr_q      <= req_addr[22:2];
                                ip_data_mask_q <= 4'h0;
                                state_q        <= S_RD_ISSUE;
                            end
                        end
                    end
                    S_RD_ISSUE: begin
                        cnt_q   <= '0;
                        state_q <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (ip_rd_data_valid) begin
                            cache_word_q  <= ip_rd_data;
                            cache_tag_q   <= ip_addr_q;
                            cache_valid_q <= 1'b1;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= ip_rd_data[{lane_q, 3'b000} +: 8];
                            state_q       <= S_IDLE;
                        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                            cache_valid_q <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_err_q     <= 1'b1;
                            rsp_rdata_q   <= 8'hFF;
                            state_q       <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WR_ISSUE: begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        cnt_q       <= '0;
                        state_q     <= (WR_GAP == 0) ? S_IDLE : S_WR_GAP;
                    end
                    S_WR_GAP: begin
                        if (cnt_q == CNT_W'(WR_GAP - 1)) state_q <= S_IDLE;
                        else cnt_q <= cnt_q + 1'b1;
                    end
                    default: state_q <= S_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_byte_bridge.sv
// tb/tb_psram_byte_bridge.sv - scoreboard bench for psram_byte_bridge
// Reference: byte-addressed memory plus a one-entry valid/tag cache model.
module tb_psram_byte_bridge;

    localparam int WR_GAP = 255;
    localparam int TO_LAT = 65;

    logic        clk = 1'b0;
    logic        rst_n, calib_in, req_valid, req_we;
    logic [22:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ready, rsp_valid, rsp_err, ready_o, busy;
    logic [7:0]  rsp_rdata;
    logic        ip_cmd, ip_cmd_en;
    logic [20:0] ip_addr;
    logic [31:0] ip_wr_data;
    logic [3:0]  ip_data_mask;
    logic [31:0] ip_rd_data = 32'h0;
    logic        ip_rd_data_valid = 1'b0;

    psram_byte_bridge dut (
        .clk(clk), .rst_n(rst_n), .calib_in(calib_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ready_o(ready_o), .busy(busy),
        .ip_cmd(ip_cmd), .ip_cmd_en(ip_cmd_en), .ip_addr(ip_addr),
        .ip_wr_data(ip_wr_data), .ip_data_mask(ip_data_mask),
        .ip_rd_data(ip_rd_data), .ip_rd_data_valid(ip_rd_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic [7:0] rdata; bit chk_data; int acc; int lat; } rsp_t;
    typedef struct { logic cmd; logic [20:0] addr; logic [31:0] wd; logic [3:0] mask; } cmd_t;

    rsp_t exp_q[$];
    cmd_t cmd_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] psram [int];
    int   checks = 0, errors = 0, cyc = 0, cmd_cnt = 0;
    bit   ref_valid = 0, model_silent = 0, prev_en = 0, tail_pend = 0;
    logic [20:0] ref_tag = '0, pend_addr = '0;
    int   wait_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [20:0] w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h3C855AA5;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [20:0] w);
        return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_word(w);
    endfunction

    function automatic logic [31:0] ps_rd(input logic [20:0] w);
        return psram.exists(int'(w)) ? psram[int'(w)] : init_word(w);
    endfunction

    // PSRAM model: applies masked writes, answers reads after 1..6 cycles, sometimes adds a tail beat.
    always @(negedge clk) begin
        logic [31:0] w;
        ip_rd_data_valid = 1'b0;
        if (tail_pend) begin
            ip_rd_data_valid = 1'b1;
            ip_rd_data = $urandom;
            tail_pend = 0;
        end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                ip_rd_data_valid = 1'b1;
                ip_rd_data = ps_rd(pend_addr);
                tail_pend = ($urandom_range(0, 1) == 1);
            end
        end
        if (rst_n && ip_cmd_en) begin
            if (ip_cmd) begin
                w = ps_rd(ip_addr);
                for (int b = 0; b < 4; b++)
                    if (!ip_data_mask[b]) w[b*8 +: 8] = ip_wr_data[b*8 +: 8];
                psram[int'(ip_addr)] = w;
            end else if (!model_silent) begin
                pend_addr = ip_addr;
                wait_cnt = $urandom_range(1, 6);
            end
        end
    end

    always @(negedge clk) begin
        cmd_t c;
        if (rst_n && ip_cmd_en) begin
            cmd_cnt++;
            chk("cmd_adjacent", {31'b0, prev_en}, 32'd0);
            if (cmd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_unexpected actual=addr %0h expected=no command", ip_addr);
            end else begin
                c = cmd_q.pop_front();
                chk("cmd_dir", {31'b0, ip_cmd}, {31'b0, c.cmd});
                chk("cmd_addr", {11'b0, ip_addr}, {11'b0, c.addr});
                chk("cmd_mask", {28'b0, ip_data_mask}, {28'b0, c.mask});
                if (c.cmd) chk("cmd_wdata", ip_wr_data, c.wd);
            end
        end
        prev_en = ip_cmd_en;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected actual=rdata %0h expected=no response", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                if (e.chk_data) chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e.rdata});
                if (e.lat >= 0) chk("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic do_req(input bit we, input logic [22:0] addr, input logic [7:0] wd,
                          input bit force_err, output int acc);
        int n = 0;
        logic [20:0] w;
        int lane;
        logic [31:0] word;
        rsp_t e;
        cmd_t c;
        bit hit;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        w = addr[22:2];
        lane = int'(addr[1:0]);
        word = ref_rd(w);
        e.acc = acc;
        if (we) begin
            c.cmd = 1'b1; c.addr = w; c.wd = {4{wd}}; c.mask = ~(4'b0001 << lane);
            cmd_q.push_back(c);
            word[lane*8 +: 8] = wd;
            ref_mem[int'(w)] = word;
            e.err = 1'b0; e.rdata = 8'h00; e.chk_data = 0; e.lat = 1;
        end else begin
            hit = ref_valid && (ref_tag == w);
            e.err = 1'b0; e.rdata = word[lane*8 +: 8]; e.chk_data = 1; e.lat = hit ? 0 : -1;
            if (!hit) begin
                c.cmd = 1'b0; c.addr = w; c.wd = '0; c.mask = 4'h0;
                cmd_q.push_back(c);
                ref_valid = !model_silent;
                ref_tag = w;
                if (model_silent) begin e.err = 1'b1; e.rdata = 8'hFF; e.lat = TO_LAT; end
            end
        end
        if (force_err) begin
            e.err = 1'b1; e.rdata = 8'hFF; e.chk_data = 1; e.lat = -1;
            ref_valid = 0;
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("rsp_outstanding", exp_q.size(), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, c0, tmp;
        rst_n = 1'b0; calib_in = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd0);
        chk("rst_cmd_en", {31'b0, ip_cmd_en}, 32'd0);
        chk("rst_ip_addr", {11'b0, ip_addr}, 32'd0);
        chk("rst_wr_data", ip_wr_data, 32'd0);
        chk("rst_mask", {28'b0, ip_data_mask}, 32'd0);
        chk("rst_busy_init", {31'b0, busy}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Calibration bring-up; a request held during the synchronizer delay must be ignored.
        calib_in = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 23'h10;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk("ready_edge", {31'b0, req_ready}, (e == 4) ? 32'd1 : 32'd0);
        end
        req_valid = 1'b0;
        idle(2);

        do_req(1, 23'h000000, 8'hA5, 0, a1);
        do_req(0, 23'h000000, 8'h00, 0, a1);
        wait_done();
        idle(2);
        c0 = cmd_cnt;
        do_req(0, 23'h000001, 8'h00, 0, a1);
        do_req(0, 23'h000002, 8'h00, 0, a1);
        do_req(0, 23'h000003, 8'h00, 0, a1);
        wait_done();
        idle(2);
        chk("hit_cmd_count", cmd_cnt - c0, 32'd0);

        model_silent = 1;
        do_req(0, 23'h000004, 8'h00, 0, a1);
        wait_done();
        model_silent = 0;
        do_req(0, 23'h000000, 8'h00, 0, a1);
        wait_done();

        model_silent = 1;
        do_req(0, 23'h000008, 8'h00, 1, a1);
        idle(5);
        calib_in = 1'b0;
        wait_done();
        idle(3);
        chk("calib_busy", {31'b0, busy}, 32'd1);
        chk("calib_req_ready", {31'b0, req_ready}, 32'd0);
        chk("calib_ready_o", {31'b0, ready_o}, 32'd0);
        calib_in = 1'b1;
        model_silent = 0;
        idle(6);
        c0 = cmd_cnt;
        do_req(0, 23'h000002, 8'h00, 0, a1);
        wait_done();
        idle(2);
        chk("calib_recache_cmd", cmd_cnt - c0, 32'd1);

        do_req(1, 23'h000006, 8'h3C, 0, a1);
        do_req(1, 23'h000001, 8'hC3, 0, a2);
        checks++;
        if (a2 - a1 < WR_GAP + 2) begin
            errors++;
            $display("FAIL wr_gap actual=%0d expected>=%0d", a2 - a1, WR_GAP + 2);
        end
        wait_done();

        for (int i = 0; i < 40; i++) begin
            tmp = $urandom_range(0, 3);
            do_req(tmp == 0, {18'b0, 3'($urandom_range(0, 5)), 2'($urandom_range(0, 3))},
                   8'($urandom), 0, a1);
            idle($urandom_range(0, 2));
        end
        wait_done();
        idle(10);
        chk("final_rsp_queue", exp_q.size(), 32'd0);
        chk("final_cmd_queue", cmd_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
